serial_word_deserializer: RTL
=============================

Name: serial_word_deserializer

Overview:
- Receive-side counterpart of the parameterized serial-out shift register: captures a framed serial bitstream one bit per enable strobe.
- Assembles `w`-bit words and presents them on a parallel output with a valid/ready handshake.
- Sits between a serial link (driven by the shift-register transmitter) and parallel consumer logic.
- One-word holding register, so the next word can shift in while the current one waits for the consumer.

Parameters:
- w, 4, data word width in bits (w >= 2).
- shift_direction, "left", bit order. "left": first received bit ends in q[w-1] (MSB-first). "right": first received bit ends in q[0] (LSB-first).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- aclr_n  input  1  asynchronous active-low reset; clears all state immediately.
- sclr  input  1  synchronous clear; same effect as reset at next clk edge.
- en  input  1  bit strobe; SI and sync are sampled only when en=1.
- SI  input  1  serial data in.
- sync  input  1  start-of-word marker, qualified by en; marks the bit on SI as data bit 0.
- q_ready  input  1  consumer accepts q when q_valid=1.
- q  output  w  assembled word.
- q_valid  output  1  q holds an unconsumed word.
- busy  output  1  a word is partially received (state SHIFT or PARITY).
- overrun  output  1  sticky; a completed word was dropped.
- frame_err  output  1  one-cycle pulse; sync arrived mid-word.
- parity_err  output  1  parity result for the word currently in q.

Behaviour:
- Reset values (aclr_n=0, or sclr=1 at an edge): state IDLE, bit counter 0, shift register 0, q=0, q_valid=0, busy=0, overrun=0, frame_err=0, parity_err=0.
- Priority: aclr_n > sclr > normal operation.
- en=0: shift register, counter and state hold. The handshake still operates.
- States: IDLE, SHIFT, PARITY. PARITY exists only with the optional feature.
- IDLE:
  - en=1, sync=1: capture SI as bit 0, counter=1, go to SHIFT.
  - en=1, sync=0: bit ignored.
- SHIFT, on each en=1:
  - Capture SI. "left" shifts as {sr[w-2:0],SI}; "right" shifts as {SI,sr[w-1:1]}.
  - Increment the counter.
  - When the captured bit is bit w-1, the word is complete: publish it (or go to PARITY when parity is enabled), then return to IDLE with counter 0.
- Mid-word sync: en=1, sync=1 while in SHIFT/PARITY with counter != 0:
  - Discard the partial word.
  - Pulse frame_err for one cycle.
  - The current bit becomes bit 0, counter=1, state SHIFT.
- Publish occurs at the same clk edge that samples the last bit, so q and q_valid are visible the next cycle (1-cycle latency).
- Handshake:
  - Transfer occurs on an edge where q_valid=1 and q_ready=1.
  - q_valid clears after a transfer unless a publish happens at the same edge.
  - Publish with transfer at the same edge: q loads the new word and q_valid stays 1.
  - Publish while q_valid=1 and q_ready=0: new word dropped, q unchanged, overrun set to 1 and held until reset or sclr.
  - q and parity_err are stable while q_valid=1 and no transfer has occurred.
- busy=1 exactly when the state is SHIFT or PARITY.
- Back-to-back words (sync on the strobe immediately after the last bit) are accepted with no gap.
- Reset mid-word: the partial word is discarded and the next word needs a fresh sync.

Optional Feature:
- Macro: SERIAL_WORD_DESERIALIZER_PARITY_EN.
- Defined:
  - After bit w-1, enter PARITY. The next en=1 bit is the parity bit.
  - The word is published on the parity-bit edge, with parity_err = XOR of the w data bits and the parity bit (even parity; 1 = error).
  - sync on the parity strobe is treated as mid-word sync.
- Undefined: no PARITY state, word published on bit w-1, parity_err tied to 0.

Test Plan:
- w=4, "left", q_ready=1: en bits 1,0,1,1 with sync on the first -> q=4'b1011 with q_valid=1 for one cycle, frame_err=0, overrun=0.
- w=4, "right", same stimulus -> q=4'b1101.
- q_ready=0: word 1 = 1,1,0,0, then word 2 = 0,1,0,1 -> q stays 4'b1100, overrun=1. Raise q_ready -> q_valid clears the next cycle, overrun stays 1 until sclr.
- Stream 1,0, then sync with bits 0,1,1,0 -> frame_err pulses one cycle at the second sync, q=4'b0110 ("left").
- aclr_n low after 2 of 4 bits -> all outputs 0 immediately. Bits 1,1 without sync are ignored. A full synced word 0,0,1,1 -> q=4'b0011.
- PARITY_EN defined: bits 1,0,1,1 with parity 1 -> parity_err=0; parity 0 -> parity_err=1; q=4'b1011 in both cases, q_valid one cycle after the parity strobe.

Source files
------------

// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel receiver with a one-word valid/ready holding register.
// Define SERIAL_WORD_DESERIALIZER_PARITY_EN to expect an even-parity bit after each word.
module serial_word_deserializer #(
    parameter int    w               = 4,
    parameter string shift_direction = "left"
) (
    input  logic         clk,
    input  logic         aclr_n,
    input  logic         sclr,
    input  logic         en,
    input  logic         SI,
    input  logic         sync,
    input  logic         q_ready,
    output logic [w-1:0] q,
    output logic         q_valid,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err,
    output logic         parity_err
);

    localparam int CW     = $clog2(w + 1);
    localparam bit C_LEFT = (shift_direction == "left");

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [w-1:0]   r_sr, w_sr_nxt, w_pub_word;
    logic           w_pub, w_frame;
    logic [w-1:0]   r_q;
    logic           r_q_valid, r_overrun, r_frame_err;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    logic           w_pub_perr;
    logic           r_parity_err;
`endif

    function automatic logic [w-1:0] f_shift(input logic [w-1:0] s, input logic b);
        if (C_LEFT) return {s[w-2:0], b};
        else        return {b, s[w-1:1]};
    endfunction

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)   r_state <= IDLE;
        else if (sclr) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // A sync strobe always restarts the word, whatever state we are in.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_pub       = 1'b0;
        w_pub_word  = r_sr;
        w_frame     = 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
        w_pub_perr  = 1'b0;
`endif
        if (en) begin
            if (sync) begin
                w_frame     = (r_state != IDLE);
                w_sr_nxt    = f_shift('0, SI);
                w_cnt_nxt   = CW'(1);
                w_state_nxt = SHIFT;
            end else begin
                case (r_state)
                    SHIFT: begin
                        w_sr_nxt  = f_shift(r_sr, SI);
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == CW'(w - 1)) begin
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_pub       = 1'b1;
                            w_pub_word  = f_shift(r_sr, SI);
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
`endif
                        end
                    end
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
                    PARITY: begin
                        w_pub       = 1'b1;
                        w_pub_word  = r_sr;
                        w_pub_perr  = (^r_sr) ^ SI;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else if (sclr) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_sr  <= w_sr_nxt;
        end
    end

    // Holding register: a publish into a full, stalled slot is dropped and flagged.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_q          <= '0;
            r_q_valid    <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else if (sclr) begin
            r_q          <= '0;
            r_q_valid    <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_frame;
            if (w_pub) begin
                if (!r_q_valid || q_ready) begin
                    r_q          <= w_pub_word;
                    r_q_valid    <= 1'b1;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
                    r_parity_err <= w_pub_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_q_valid && q_ready) begin
                r_q_valid <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
